// File: rtl/scan_pkg.sv
// Shared types, decoder-enable constants and digit-search helpers for the
// display scan address generator.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // {G1, G2A, G2B} for a disabled and an enabled 3-to-8 decoder
  localparam logic [2:0] DIS_G = 3'b011;
  localparam logic [2:0] EN_G  = 3'b100;

  typedef struct packed {
    logic [2:0] idx;
    logic       wrap;
  } next_t;

  // Nearest set mask bit strictly after addr in the scan direction; wrap flags a pass boundary
  function automatic next_t next_digit(input logic [2:0] addr, input logic [7:0] mask,
                                       input logic dir);
    next_t      res;
    logic [2:0] cand;
    res.idx  = addr;
    res.wrap = 1'b0;
    for (int i = 8; i >= 1; i--) begin
      cand = dir ? (addr - 3'(i)) : (addr + 3'(i));
      if (mask[cand]) res.idx = cand;
    end
    res.wrap = dir ? (res.idx >= addr) : (res.idx <= addr);
    return res;
  endfunction

  // Nearest set mask bit starting at addr itself, searching in the scan direction
  function automatic logic [2:0] first_digit(input logic [2:0] addr, input logic [7:0] mask,
                                             input logic dir);
    logic [2:0] res;
    logic [2:0] cand;
    res = addr;
    for (int i = 7; i >= 0; i--) begin
      cand = dir ? (addr - 3'(i)) : (addr + 3'(i));
      if (mask[cand]) res = cand;
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_addr_gen_if.sv
// Control/decoder bundle of scan_addr_gen. Defining SCAN_ADDR_GEN_DIR_EN
// adds the DIR (scan direction) input.
interface scan_addr_gen_if;
  logic       RUN;
  logic [7:0] EN_MASK;
`ifdef SCAN_ADDR_GEN_DIR_EN
  logic       DIR;
`endif
  logic       G1;
  logic       G2A;
  logic       G2B;
  logic       C;
  logic       B;
  logic       A;
  logic       SCAN_DONE;

`ifdef SCAN_ADDR_GEN_DIR_EN
  modport master (output RUN, EN_MASK, DIR, input G1, G2A, G2B, C, B, A, SCAN_DONE);
  modport slave  (input RUN, EN_MASK, DIR, output G1, G2A, G2B, C, B, A, SCAN_DONE);
`else
  modport master (output RUN, EN_MASK, input G1, G2A, G2B, C, B, A, SCAN_DONE);
  modport slave  (input RUN, EN_MASK, output G1, G2A, G2B, C, B, A, SCAN_DONE);
`endif
endinterface

// File: rtl/scan_prescaler.sv
// Free-running modulo-DIV counter producing a one-cycle tick on its last count;
// clr holds it at zero so every state starts a fresh tick period.
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_r;

  assign tick = (count_r == LAST);

  // Prescaler count with synchronous reset and clear
  always_ff @(posedge clk) begin
    if (!rst_l || clr) begin
      count_r <= '0;
    end else if (tick) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

endmodule

// File: rtl/scan_addr_gen.sv
// Digit scan sequencer driving a 3-to-8 active-low decoder: IDLE/BLANK/SHOW FSM
// with masked digit skipping. Optional SCAN_ADDR_GEN_DIR_EN enables downward scan.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input logic             CLK,
  input logic             RST_L,
  scan_addr_gen_if.slave  bus
);

  localparam int            TMAX       = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int            TW         = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = (BLANK > 0) ? TW'(BLANK - 1) : '0;
  localparam scan_state_e   ST_AFTER   = (BLANK > 0) ? ST_BLANK : ST_SHOW;

  scan_state_e   state_r, state_nxt_s;
  logic [2:0]    addr_r, addr_nxt_s;
  logic [TW-1:0] ticks_r, ticks_nxt_s;
  logic [2:0]    g_r;
  logic          done_r, done_nxt_s;
  logic          tick_s, clr_s, dir_s;
  logic [2:0]    first_s;
  next_t         step_s;

`ifdef SCAN_ADDR_GEN_DIR_EN
  assign dir_s = bus.DIR;
`else
  assign dir_s = 1'b0;
`endif

  // Leaving any state happens on a tick wrap or through IDLE, so only IDLE/stop clear it
  assign clr_s = (state_r == ST_IDLE) || !bus.RUN;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (CLK),
    .rst_l (RST_L),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Next-state, address and pass-boundary decision
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    ticks_nxt_s = ticks_r;
    done_nxt_s  = 1'b0;
    first_s     = first_digit(addr_r, bus.EN_MASK, dir_s);
    step_s      = next_digit(addr_r, bus.EN_MASK, dir_s);
    if (!bus.RUN) begin
      state_nxt_s = ST_IDLE;
      addr_nxt_s  = 3'd0;
      ticks_nxt_s = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.EN_MASK != 8'h00) begin
            state_nxt_s = ST_AFTER;
            addr_nxt_s  = first_s;
            ticks_nxt_s = '0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BLANK: begin
          if (tick_s && (ticks_r == BLANK_LAST)) begin
            state_nxt_s = ST_SHOW;
            ticks_nxt_s = '0;
          end else if (tick_s) begin
            ticks_nxt_s = ticks_r + TW'(1);
          end else begin
            ticks_nxt_s = ticks_r;
          end
        end
        ST_SHOW: begin
          if (tick_s && (ticks_r == DWELL_LAST)) begin
            ticks_nxt_s = '0;
            // An empty mask parks in IDLE keeping the address for the restart search
            if (bus.EN_MASK == 8'h00) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_AFTER;
              addr_nxt_s  = step_s.idx;
              done_nxt_s  = step_s.wrap;
            end
          end else if (tick_s) begin
            ticks_nxt_s = ticks_r + TW'(1);
          end else begin
            ticks_nxt_s = ticks_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          addr_nxt_s  = 3'd0;
          ticks_nxt_s = '0;
        end
      endcase
    end
  end

  // State and registered decoder outputs
  always_ff @(posedge CLK) begin
    if (!RST_L) begin
      state_r <= ST_IDLE;
      addr_r  <= 3'd0;
      ticks_r <= '0;
      g_r     <= DIS_G;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      ticks_r <= ticks_nxt_s;
      g_r     <= (state_nxt_s == ST_SHOW) ? EN_G : DIS_G;
      done_r  <= done_nxt_s;
    end
  end

  assign {bus.G1, bus.G2A, bus.G2B} = g_r;
  assign {bus.C, bus.B, bus.A}      = addr_r;
  assign bus.SCAN_DONE              = done_r;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed self-checking bench for scan_addr_gen: a DIV=4/DWELL=2/BLANK=1 unit
// and a DIV=1/DWELL=1/BLANK=0 unit; DIR scan checked when SCAN_ADDR_GEN_DIR_EN is set.
module tb_scan_addr_gen;

  localparam logic [2:0] DIS = 3'b011;
  localparam logic [2:0] ENA = 3'b100;

  logic clk = 1'b0;
  logic rst_l;
  int   checks = 0;
  int   errors = 0;

  scan_addr_gen_if bus();
  scan_addr_gen_if bus_f();

  scan_addr_gen #(.DIV(4), .DWELL(2), .BLANK(1)) dut (
    .CLK   (clk),
    .RST_L (rst_l),
    .bus   (bus)
  );

  scan_addr_gen #(.DIV(1), .DWELL(1), .BLANK(0)) dut_f (
    .CLK   (clk),
    .RST_L (rst_l),
    .bus   (bus_f)
  );

  always #5 clk = ~clk;

  // {G1,G2A,G2B,C,B,A,SCAN_DONE}
  logic [6:0] obs_m, obs_f;
  assign obs_m = {bus.G1, bus.G2A, bus.G2B, bus.C, bus.B, bus.A, bus.SCAN_DONE};
  assign obs_f = {bus_f.G1, bus_f.G2A, bus_f.G2B, bus_f.C, bus_f.B, bus_f.A, bus_f.SCAN_DONE};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_l         = 1'b0;
    bus.RUN       = 1'b1;
    bus.EN_MASK   = 8'hFF;
    bus_f.RUN     = 1'b0;
    bus_f.EN_MASK = 8'h01;
`ifdef SCAN_ADDR_GEN_DIR_EN
    bus.DIR   = 1'b0;
    bus_f.DIR = 1'b0;
`endif
    step();
    step();
    checks++;
    if (obs_m !== {DIS, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_main got %b exp %b", obs_m, {DIS, 3'd0, 1'b0});
    end
    checks++;
    if (obs_f !== {DIS, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_fast got %b exp %b", obs_f, {DIS, 3'd0, 1'b0});
    end
  endtask

  task automatic test_full_scan();
    logic [6:0] exp;
    logic [2:0] a;
    logic       en, d;
    rst_l = 1'b1;
    for (int n = 0; n <= 234; n++) begin
      step();
      en  = (n % 12) >= 4;
      a   = 3'((n / 12) % 8);
      d   = (n > 0) && ((n % 96) == 0);
      exp = {en ? ENA : DIS, a, d};
      checks++;
      if (obs_m !== exp) begin
        errors++;
        $display("FAIL full_scan n=%0d got %b exp %b", n, obs_m, exp);
      end
    end
  endtask

  task automatic test_run_drop();
    logic [6:0] exp;
    bus.RUN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_m !== {DIS, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL run_drop i=%0d got %b exp %b", i, obs_m, {DIS, 3'd0, 1'b0});
      end
    end
    bus.RUN = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      step();
      exp = {(n >= 4) ? ENA : DIS, 3'd0, 1'b0};
      checks++;
      if (obs_m !== exp) begin
        errors++;
        $display("FAIL run_restart n=%0d got %b exp %b", n, obs_m, exp);
      end
    end
  endtask

  task automatic test_sparse_mask();
    logic [2:0] seq [3];
    logic [6:0] exp;
    logic       en, d;
    seq[0] = 3'd0;
    seq[1] = 3'd2;
    seq[2] = 3'd7;
    bus.RUN = 1'b0;
    step();
    bus.EN_MASK = 8'b1000_0101;
    bus.RUN     = 1'b1;
    for (int n = 0; n <= 104; n++) begin
      step();
      en  = (n % 12) >= 4;
      d   = (n > 0) && ((n % 36) == 0);
      exp = {en ? ENA : DIS, seq[(n / 12) % 3], d};
      checks++;
      if (obs_m !== exp) begin
        errors++;
        $display("FAIL sparse n=%0d got %b exp %b", n, obs_m, exp);
      end
    end
  endtask

  task automatic test_mask_zero();
    logic [6:0] exp;
    bus.EN_MASK = 8'h00;
    for (int n = 105; n <= 110; n++) begin
      step();
      exp = {(n <= 107) ? ENA : DIS, 3'd7, 1'b0};
      checks++;
      if (obs_m !== exp) begin
        errors++;
        $display("FAIL mask_zero n=%0d got %b exp %b", n, obs_m, exp);
      end
    end
    bus.EN_MASK = 8'h10;
    for (int k = 0; k <= 4; k++) begin
      step();
      exp = {(k >= 4) ? ENA : DIS, 3'd4, 1'b0};
      checks++;
      if (obs_m !== exp) begin
        errors++;
        $display("FAIL mask_restore k=%0d got %b exp %b", k, obs_m, exp);
      end
    end
  endtask

  task automatic test_fast();
    logic [6:0] exp;
    bus_f.RUN = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      exp = {ENA, 3'd0, n >= 1};
      checks++;
      if (obs_f !== exp) begin
        errors++;
        $display("FAIL fast n=%0d got %b exp %b", n, obs_f, exp);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [6:0] exp;
    logic [2:0] a;
    logic       en, d, dir_mode;
    int         k;
    rst_l = 1'b0;
    step();
    checks++;
    if (obs_m !== {DIS, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_main got %b exp %b", obs_m, {DIS, 3'd0, 1'b0});
    end
    checks++;
    if (obs_f !== {DIS, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_fast got %b exp %b", obs_f, {DIS, 3'd0, 1'b0});
    end
`ifdef SCAN_ADDR_GEN_DIR_EN
    bus.DIR  = 1'b1;
    dir_mode = 1'b1;
`else
    dir_mode = 1'b0;
`endif
    bus.EN_MASK = 8'hFF;
    rst_l       = 1'b1;
    for (int n = 0; n <= 100; n++) begin
      step();
      k   = (n / 12) % 8;
      en  = (n % 12) >= 4;
      a   = dir_mode ? 3'(8 - k) : 3'(k);
      d   = dir_mode ? ((n % 96) == 12) : ((n > 0) && ((n % 96) == 0));
      exp = {en ? ENA : DIS, a, d};
      checks++;
      if (obs_m !== exp) begin
        errors++;
        $display("FAIL post_reset_scan n=%0d got %b exp %b", n, obs_m, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_run_drop();
    test_sparse_mask();
    test_mask_zero();
    test_fast();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_addr_gen.md
Name: scan_addr_gen

Overview:
- Upstream driver for the 3-to-8 active-low decoder in the display path. It produces the decoder's enable triple (G1, G2A, G2B) and select lines (C, B, A).
- It steps through the eight digit positions at a human-visible rate. It skips masked-off positions and inserts anti-ghosting blank intervals between digits.
- It sits between the board clock and the decoder, which turns its outputs into one-hot active-low digit strobes.

Parameters:
- DIV, 50000, clock cycles per tick (prescaler modulus); legal range ≥1.
- DWELL, 4, ticks each digit is shown (SHOW state length); legal range ≥1.
- BLANK, 1, ticks the decoder is disabled between digits; 0 means no blank interval.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST_L  input  1  synchronous active-low reset, sampled on CLK rising edge.
- RUN  input  1  level; 1 = scanning enabled, 0 = stop and disable decoder.
- EN_MASK  input  8  bit i = 1 means digit position i takes part in the scan.
- G1  output  1  decoder enable, active high.
- G2A  output  1  decoder enable, active low.
- G2B  output  1  decoder enable, active low.
- C  output  1  select MSB.
- B  output  1  select middle bit.
- A  output  1  select LSB.
- SCAN_DONE  output  1  one-cycle pulse at the end of the last digit of each full pass.

Behaviour:
- All outputs are registered.
- Reset (RST_L=0 at an edge): state IDLE, prescaler=0, tick count=0, addr=0, G1=0, G2A=1, G2B=1, {C,B,A}=3'b000, SCAN_DONE=0. Reset overrides RUN in the same cycle.
- Decoder enable is defined as G1=1, G2A=0, G2B=0. "Disabled" means G1=0, G2A=1, G2B=1.
- {C,B,A} always equals addr, in every state.
- Prescaler counts 0..DIV-1; tick asserts in the cycle where count==DIV-1. Prescaler and tick count clear on every state entry, so a state of N ticks lasts exactly N*DIV cycles.
- State IDLE: outputs disabled.
  - RUN=1 with mask≠0 → BLANK if BLANK>0, else SHOW.
  - addr is loaded with the lowest set mask bit ≥ current addr; if none, the lowest set bit.
- State BLANK: outputs disabled. After BLANK ticks → SHOW.
- State SHOW: outputs enabled. After DWELL ticks:
  - addr ← next set mask bit strictly after addr, wrapping 7→0.
  - Next state is BLANK, or SHOW again if BLANK=0.
  - When the next addr ≤ current addr (wrap), SCAN_DONE=1 for exactly that one cycle.
- Single-bit mask: addr stays constant; SCAN_DONE pulses at the end of every SHOW.
- EN_MASK is sampled only at the IDLE→run transition and at SHOW end. Mid-dwell changes do not affect the current digit.
- EN_MASK becomes 8'h00 at a sampling point → go to IDLE (outputs disabled, addr held). Restart automatically when the mask becomes nonzero and RUN=1.
- RUN=0 in any state → IDLE at the next edge: outputs disabled, addr reset to 0, SCAN_DONE=0, no pulse.
- First enabled digit appears BLANK*DIV cycles after the edge that samples RUN=1.

Optional Feature:
- Macro SCAN_ADDR_GEN_DIR_EN.
- Defined: adds input port DIR (1 bit).
  - DIR=1 scans downward: next = next set mask bit strictly below addr, wrapping 0→7.
  - Wrap detection becomes next ≥ current.
  - IDLE entry picks the highest set bit ≤ addr.
  - DIR is sampled at the same points as EN_MASK.
- Undefined: no DIR port; upward scan only, exactly as above.

Decomposition:
- Shared package scan_pkg holds:
  - state enum {IDLE, BLANK, SHOW} (2-bit);
  - DIS_G triple constant (0,1,1) and EN_G triple constant (1,0,0);
  - function next_digit(addr, mask, dir) returning a 3-bit index plus a wrap flag.
- One sub-module: scan_prescaler (DIV parameter, clear input, tick output).

Test Plan (DIV=4, DWELL=2, BLANK=1 unless stated):
- Reset, then RUN=1, EN_MASK=8'hFF at cycle 0 → outputs disabled for cycles 1–4; {C,B,A}=0 enabled for cycles 5–12; blank for 4 cycles; then addr 1. SCAN_DONE pulses once every 96 cycles, at the end of digit 7.
- EN_MASK=8'b1000_0101 → addr sequence 0,2,7,0…; SCAN_DONE at each 7→0 step; pass period 36 cycles.
- BLANK=0, DWELL=1, DIV=1, mask=8'h01 → G1=1 continuously, {C,B,A}=0, SCAN_DONE high every cycle.
- RUN dropped during SHOW of addr 3 → next cycle G1=0, G2A=1, G2B=1, addr=0, no SCAN_DONE. RUN reasserted → restarts at digit 0 after 4 cycles.
- Mask changed to 8'h00 mid-dwell → current digit completes its full 8 cycles, then IDLE with outputs disabled. Mask back to 8'h10 → digit 4 shown after 4 blank cycles.
- RST_L=0 asserted mid-scan while RUN=1 → all outputs at reset values on the next edge. With SCAN_ADDR_GEN_DIR_EN defined and DIR=1, mask=8'hFF, the sequence after restart is 0,7,6,…,1, with SCAN_DONE on 0→7.
